// File: rtl/alu_pkg.sv
// Shared constants for the JARVIS execute stage: datapath width and ALU opcodes.
// The decoder and branch unit import the same opcode names.
package alu_pkg;

  localparam int XLEN = 32;
  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_ADD  = 6'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 6'd1;
  localparam logic [OP_W-1:0] OP_SLL  = 6'd2;
  localparam logic [OP_W-1:0] OP_SLT  = 6'd3;
  localparam logic [OP_W-1:0] OP_SLTU = 6'd4;
  localparam logic [OP_W-1:0] OP_XOR  = 6'd5;
  localparam logic [OP_W-1:0] OP_SRL  = 6'd6;
  localparam logic [OP_W-1:0] OP_SRA  = 6'd7;
  localparam logic [OP_W-1:0] OP_OR   = 6'd8;
  localparam logic [OP_W-1:0] OP_AND  = 6'd9;

endpackage

// File: rtl/alu_shifter.sv
// Combinational logarithmic barrel shifter for SLL/SRL/SRA.
// Left shifts reuse the right-shift stages by bit-reversing input and output.
module alu_shifter #(
  parameter int WIDTH = alu_pkg::XLEN,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  input  logic             shift_right,
  input  logic             arith,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] a_rev;
  logic [WIDTH-1:0] stage_in;
  logic [WIDTH-1:0] stage [0:SHW];
  logic [WIDTH-1:0] out_rev;
  logic             fill;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rev
      assign a_rev[gi]   = a[WIDTH-1-gi];
      assign out_rev[gi] = stage[SHW][WIDTH-1-gi];
    end
  endgenerate

  // Sign fill only applies to arithmetic right shifts.
  assign fill     = shift_right & arith & a[WIDTH-1];
  assign stage_in = shift_right ? a : a_rev;
  assign stage[0] = stage_in;

  generate
    for (gi = 0; gi < SHW; gi++) begin : g_stage
      localparam int S = 1 << gi;
      assign stage[gi+1] = shamt[gi] ? {{S{fill}}, stage[gi][WIDTH-1:S]} : stage[gi];
    end
  endgenerate

  assign y = shift_right ? stage[SHW] : out_rev;

endmodule

// File: rtl/alu.sv
// RV32I-style integer ALU with a single registered result stage.
// One operation per cycle; result appears one clock after its operands.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  alu_op,
  output logic [WIDTH-1:0] result
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] shift_y;
  logic             lt_signed;
  logic             lt_unsigned;
  logic             shift_right;
  logic             shift_arith;

  assign sum         = a + b;
  assign diff        = a - b;
  assign lt_signed   = $signed(a) < $signed(b);
  assign lt_unsigned = a < b;
  assign shift_right = (alu_op == OP_SRL) || (alu_op == OP_SRA);
  assign shift_arith = (alu_op == OP_SRA);

  alu_shifter #(
    .WIDTH(WIDTH),
    .SHW  (SHW)
  ) u_shifter (
    .a          (a),
    .shamt      (b[SHW-1:0]),
    .shift_right(shift_right),
    .arith      (shift_arith),
    .y          (shift_y)
  );

  always_comb begin
    result_d = '0;
    case (alu_op)
      OP_ADD:  result_d = sum;
      OP_SUB:  result_d = diff;
      OP_SLL:  result_d = shift_y;
      OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, lt_signed};
      OP_SLTU: result_d = {{(WIDTH-1){1'b0}}, lt_unsigned};
      OP_XOR:  result_d = a ^ b;
      OP_SRL:  result_d = shift_y;
      OP_SRA:  result_d = shift_y;
      OP_OR:   result_d = a | b;
      OP_AND:  result_d = a & b;
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver issues one vector per cycle and queues the
// hand-computed answer; a monitor pops and compares one cycle later.
module tb_alu;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [5:0]  alu_op;
  logic [31:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;

  sb_t sb_q[$];

  alu #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .alu_op(alu_op),
    .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: result %h", name, act);
    end
  endtask

  // Monitor: the ALU presents a fresh result after every rising edge.
  initial begin
    sb_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.name, result, e.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{OP_ADD,  32'd10,        32'd20,        32'd30,        "add_10_20"},
      '{OP_SUB,  32'hFFFFFF80,  32'hFFFFFF81,  32'hFFFFFFFF,  "sub_m128_m127"},
      '{OP_SLTU, 32'd1,         32'hFFFFFFFF,  32'd1,         "sltu_1_max"},
      '{OP_SLT,  32'hFFFFFFFF,  32'd0,         32'd1,         "slt_m1_0"},
      '{OP_SLT,  32'd0,         32'hFFFFFFFF,  32'd0,         "slt_0_m1"},
      '{OP_AND,  32'hFFFFFFFF,  32'd0,         32'd0,         "and_ones_zero"},
      '{OP_OR,   32'hFFFFFFFF,  32'd0,         32'hFFFFFFFF,  "or_ones_zero"},
      '{OP_XOR,  32'hF0F0F0F0,  32'h0F0F0F0F,  32'hFFFFFFFF,  "xor_f0_0f"},
      '{OP_SLL,  32'hFFFFFFFF,  32'd1,         32'hFFFFFFFE,  "sll_ones_1"},
      '{OP_SRL,  32'hFFFFFFFF,  32'd1,         32'h7FFFFFFF,  "srl_ones_1"},
      '{OP_SRA,  32'h80000000,  32'd1,         32'hC0000000,  "sra_msb_1"},
      '{OP_SLL,  32'd1,         32'h00000021,  32'd2,         "sll_upper_b_ignored"},
      '{OP_ADD,  32'hFFFFFFFF,  32'd1,         32'd0,         "add_wrap"},
      '{OP_SUB,  32'd0,         32'd1,         32'hFFFFFFFF,  "sub_borrow"},
      '{OP_SRA,  32'h80000000,  32'd31,        32'hFFFFFFFF,  "sra_31"},
      '{OP_SRL,  32'h80000000,  32'd31,        32'd1,         "srl_31"},
      '{OP_SRA,  32'h40000000,  32'd4,         32'h04000000,  "sra_positive"},
      '{OP_SRA,  32'h8000ABCD,  32'hFFFFFFE0,  32'h8000ABCD,  "sra_shamt0"},
      '{OP_SLL,  32'h12345678,  32'd4,         32'h23456780,  "sll_4"},
      '{OP_SLTU, 32'd7,         32'd7,         32'd0,         "sltu_equal"},
      '{OP_SLT,  32'h80000000,  32'h7FFFFFFF,  32'd1,         "slt_min_max"},
      '{OP_AND,  32'hF0F0F0F0,  32'hFF00FF00,  32'hF000F000,  "and_mixed"},
      '{6'd10,   32'h11111111,  32'h22222222,  32'd0,         "undef_op10"},
      '{6'd63,   32'h11111111,  32'h22222222,  32'd0,         "undef_op63"}
    };

    rst_n  = 1'b0;
    a      = 32'h12345678;
    b      = 32'h9ABCDEF0;
    alu_op = OP_ADD;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", result, 32'd0);

    // Back-to-back issue, one vector per cycle.
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      a      = vecs[i].a;
      b      = vecs[i].b;
      alu_op = vecs[i].op;
      sb_q.push_back('{vecs[i].exp, vecs[i].name});
      @(negedge clk);
    end

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    // Inputs changed just after an edge must not reach result before the next edge.
    @(negedge clk);
    a = 32'd1; b = 32'd2; alu_op = OP_ADD;
    @(posedge clk);
    #1;
    check("timing_first", result, 32'd3);
    #1;
    a = 32'd100; b = 32'd200;
    #1;
    check("timing_hold_after_edge", result, 32'd3);
    @(negedge clk);
    check("timing_hold_mid_cycle", result, 32'd3);
    @(posedge clk);
    #1;
    check("timing_update", result, 32'd300);

    // Asynchronous reset between edges, discarding an in-flight operation.
    @(negedge clk);
    a = 32'hAAAAAAAA; b = 32'h55555555; alu_op = OP_XOR;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_immediate", result, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", result, 32'd0);
    @(negedge clk);
    a = 32'h12300000; b = 32'h00000456; alu_op = OP_OR;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_after_reset", result, 32'h12300456);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
